alu_pipe: RTL
=============

# alu_pipe

Parametrised, handshaked successor to the 8-bit datapath ALU. It is generic in `WIDTH` and adds an extended 4-bit opcode set: carry-chained arithmetic, arithmetic and rotate shifts, compare, and an iterative shift-add multiplier. It keeps a carry/zero/negative/overflow flag register. The block sits between the register file and writeback. Operands arrive on a valid/ready channel, results leave on a second valid/ready channel, and one operation is in flight at a time.

## Interface
- `WIDTH`, default 8: datapath width; power of two, ≥ 4. `SW = log2(WIDTH)`.
- `MUL_EN`, default 1: 1 builds the multiplier; 0 makes MUL/MULH return 0 with 1-cycle latency.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `in_valid`  in  1  operand/opcode valid.
- `in_ready`  out  1  block accepts an operation this cycle.
- `op`  in  4  opcode.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B; shift amount is `b[SW-1:0]`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `result`  out  WIDTH  registered result.
- `flags`  out  4  registered {C, Z, N, V}.
- `busy`  out  1  multiplier iterating.

## Operation
Opcodes (0x0–0x7 match the legacy 3-bit encoding):
- 0 ADD: a+b.
- 1 SUB: a−b.
- 2 SLL.
- 3 SRL.
- 4 AND.
- 5 OR.
- 6 NOR.
- 7 XOR.
- 8 ADC: a+b+C.
- 9 SBC: a−b−C.
- A SRA.
- B ROL.
- C ROR.
- D MUL: low WIDTH bits of the unsigned product.
- E MULH: high WIDTH bits of the unsigned product.
- F CMP: result = a, flags as SUB.

Flag rules:
- Z = (result == 0). N = result[WIDTH−1]. For CMP, Z and N come from the difference, not from `a`.
- ADD/ADC: C = carry out; V = signed overflow.
- SUB/SBC/CMP: C = borrow (1 when the unsigned minuend is less than subtrahend + borrow-in); V = signed overflow.
- Shifts: C = last bit shifted out; C = 0 when the amount is 0. Rotates: C = the bit that wrapped. V = 0.
- Logic ops: C = V = 0.
- MUL: C = V = (high half ≠ 0). MULH: C = V = 0.

General behaviour:
- ADC/SBC read C from the flag register at the accept edge.
- The flag register and `result` are updated only on the edge that sets `out_valid`.

FSM states:
- IDLE: accepts operations.
- MUL: iterating, holds the counter, multiplicand and partial product.
- Output holding is independent: `out_valid` is a register.

Transitions and handshake:
- `in_ready = (state==IDLE) && (!out_valid || out_ready)`, forced to 0 while `rst_n` is low.
- An accept is `in_valid && in_ready`. On accept, MUL/MULH with `MUL_EN=1` go to MUL; every other op writes the result directly.
- MUL iterates exactly WIDTH cycles, one partial-product bit per cycle, then writes the result and returns to IDLE.
- `out_valid` clears on `out_ready` unless a new result is written on the same edge.
- `result` and `flags` stay stable while `out_valid && !out_ready`.
- `busy` = (state==MUL).

## Timing
- Reset values: `out_valid` 0, `result` 0, `flags` 0, `busy` 0, state IDLE, internal counter and accumulator 0.
- Single-cycle ops: accepted at edge k, `out_valid` is high after edge k. Throughput is 1 op/cycle while `out_ready` is held high.
- MUL/MULH: accepted at edge k, result after edge k+WIDTH. `in_ready` is low for edges k+1 .. k+WIDTH.
- Simultaneous drain and accept: when the old result is taken on edge k and a new op is accepted on edge k, the new result appears after edge k with no bubble.
- Reset asserted mid-MUL: aborts immediately with no residual output. After release the FSM is in IDLE and the flags are 0.
- Inputs are sampled only at the accept edge. Changes to `a`/`b`/`op` during MUL have no effect.
- Shift amounts are modulo WIDTH; upper bits of `b` are ignored for shifts.

## Test plan
All scenarios use WIDTH=8.
- ADD 0xF0+0x20 → result 0x10, C=1 Z=0 N=0 V=0. Then ADC 0x01+0x01 → 0x03, C=0.
- SUB 0x50−0x70 → 0xE0, C=1 N=1 V=0. SUB 0x80−0x01 → 0x7F, V=1 C=0. CMP 0x33,0x33 → result 0x33, Z=1.
- SLL 0x81 by 1 → 0x02, C=1. SRA 0x90 by 2 → 0xE4, C=0. ROR 0x01 by 1 → 0x80, C=1. Shift by 0 → unchanged, C=0.
- MUL 0x12×0x34 → result 0xA8, C=V=1, `out_valid` exactly 8 cycles after accept, `in_ready`=0 and `busy`=1 throughout. MULH same operands → 0x03.
- Backpressure and streaming:
  - Hold `out_ready`=0 for 3 cycles after ADD 1+2: `result` stays 0x03, `in_ready`=0.
  - Then raise `out_ready` and stream 4 ADDs on consecutive cycles: 4 results on consecutive cycles, no bubbles.
- Pull `rst_n` low on cycle 4 of a MUL: `out_valid` and `busy` drop immediately. After release, no result appears, `flags`=0 and `in_ready`=1.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked WIDTH-bit ALU with a {C,Z,N,V} flag register
// and an iterative shift-add multiplier, one operation in flight.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SLL  = 4'h2;
    localparam logic [3:0] OP_SRL  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_NOR  = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_ADC  = 4'h8;
    localparam logic [3:0] OP_SBC  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;
    localparam logic [3:0] OP_ROL  = 4'hB;
    localparam logic [3:0] OP_ROR  = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;
    localparam logic [3:0] OP_MULH = 4'hE;
    localparam logic [3:0] OP_CMP  = 4'hF;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e             state_q, state_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               hi_q, hi_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [3:0]         flags_q, flags_d;
    logic               ovalid_q, ovalid_d;

    logic               accept, is_mul, cin;
    logic               alu_c, alu_v, add_v, sub_v, mul_c;
    logic [SW-1:0]      sh;
    logic [WIDTH:0]     sum, diff, sl, sr, sa;
    logic [WIDTH-1:0]   rl, rr, alu_res, zn, mul_res;
    logic [2*WIDTH-1:0] prod;

    assign in_ready = rst_n && (state_q == S_IDLE)
                      && (!ovalid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (op == OP_MUL) || (op == OP_MULH);
    assign cin      = ((op == OP_ADC) || (op == OP_SBC)) && flags_q[3];
    assign sh       = b[SW-1:0];

    assign sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign diff  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    assign add_v = (a[WIDTH-1] == b[WIDTH-1])
                   && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_v = (a[WIDTH-1] != b[WIDTH-1])
                   && (diff[WIDTH-1] != a[WIDTH-1]);

    // One guard bit beside the operand catches the last bit shifted out.
    assign sl = {1'b0, a} << sh;
    assign sr = {a, 1'b0} >> sh;
    assign sa = $signed({a, 1'b0}) >>> sh;
    assign rl = (a << sh) | (a >> (WIDTH - int'(sh)));
    assign rr = (a >> sh) | (a << (WIDTH - int'(sh)));

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (op)
            OP_ADD, OP_ADC: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = add_v;
            end
            OP_SUB, OP_SBC: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = sub_v;
            end
            OP_CMP: begin
                alu_res = a;
                alu_c   = diff[WIDTH];
                alu_v   = sub_v;
            end
            OP_SLL: begin
                alu_res = sl[WIDTH-1:0];
                alu_c   = sl[WIDTH];
            end
            OP_SRL: begin
                alu_res = sr[WIDTH:1];
                alu_c   = sr[0];
            end
            OP_SRA: begin
                alu_res = sa[WIDTH:1];
                alu_c   = sa[0];
            end
            OP_ROL: begin
                alu_res = rl;
                alu_c   = (sh != '0) && rl[0];
            end
            OP_ROR: begin
                alu_res = rr;
                alu_c   = (sh != '0) && rr[WIDTH-1];
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOR:  alu_res = ~(a | b);
            OP_XOR:  alu_res = a ^ b;
            default: ;
        endcase
    end

    assign zn = (op == OP_CMP) ? diff[WIDTH-1:0] : alu_res;

    assign prod    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_res = hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    assign mul_c   = !hi_q && (prod[2*WIDTH-1:WIDTH] != '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        res_d    = res_q;
        flags_d  = flags_q;
        ovalid_d = ovalid_q && !out_ready;
        unique case (state_q)
            S_IDLE: begin
                if (accept && MUL_EN && is_mul) begin
                    state_d  = S_MUL;
                    cnt_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    hi_d     = (op == OP_MULH);
                end else if (accept) begin
                    res_d    = alu_res;
                    flags_d  = {alu_c, zn == '0, zn[WIDTH-1], alu_v};
                    ovalid_d = 1'b1;
                end
            end
            S_MUL: begin
                cnt_d    = cnt_q + SW'(1);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                acc_d    = prod;
                // Last partial product folds straight into the result.
                if (cnt_q == SW'(WIDTH - 1)) begin
                    state_d  = S_IDLE;
                    acc_d    = '0;
                    res_d    = mul_res;
                    flags_d  = {mul_c, mul_res == '0,
                                mul_res[WIDTH-1], mul_c};
                    ovalid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            hi_q     <= 1'b0;
            res_q    <= '0;
            flags_q  <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign out_valid = ovalid_q;
    assign result    = res_q;
    assign flags     = flags_q;
    assign busy      = (state_q == S_MUL);

endmodule
